ram_sp_be_init: RTL and testbench

- Parametrised single-port synchronous RAM; next generation of the fixed 256x32 L5 RAM.
- Adds configurable width and depth, per-byte write enables, and 1- or 2-cycle registered read latency with a read-valid strobe.
- Adds a hardware clear sequencer that fills the array with a constant after reset or on request.
- Serves as the general scratch/storage macro behind CPU-side datapaths.

---
 rtl/ram_pkg.sv | 10 +
 rtl/ram_clear_seq.sv | 32 +++
 rtl/ram_sp_be_init.sv | 70 +++++++
 tb/tb_ram_sp_be_init.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: shared types and sizing helpers for the single-port RAM
package ram_pkg;
  typedef enum logic {SWEEP, IDLE} sweep_state_t;
  function automatic int depth_of(input int addr_w);
    return 1 << addr_w;
  endfunction
  function automatic int be_w_of(input int data_w);
    return data_w / 8;
  endfunction
endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: clear-sweep FSM walking every address once after reset or clr
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              busy,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);
  sweep_state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= SWEEP;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  // the last address is all-ones; the counter wraps to 0 as the sweep ends
  always_comb begin
    state_n = clr ? SWEEP : (state == SWEEP && &cnt) ? IDLE : state;
    cnt_n   = (clr || state != SWEEP) ? '0 : cnt + 1'b1;
  end
  assign busy       = state == SWEEP;
  assign sweep_we   = busy;
  assign sweep_addr = cnt;
endmodule

// File: rtl/ram_sp_be_init.sv
// ram_sp_be_init: single-port RAM with byte enables, 1/2-cycle read latency and clear sweep
module ram_sp_be_init
  import ram_pkg::*;
#(
  parameter int                  DATA_W    = 32,
  parameter int                  ADDR_W    = 8,
  parameter int                  RD_LAT    = 1,
  parameter logic [DATA_W-1:0]   CLEAR_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cs,
  input  logic                   we,
  input  logic [DATA_W/8-1:0]    be,
  input  logic [ADDR_W-1:0]      a,
  input  logic [DATA_W-1:0]      di,
  input  logic                   oe,
  input  logic                   clr,
  output logic [DATA_W-1:0]      dout,
  output logic                   rvalid,
  output logic                   busy
);
  localparam int DEPTH = depth_of(ADDR_W);
  localparam int BE_W  = be_w_of(DATA_W);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] dout_reg, rd_data;
  logic              sweep_we, rd_req, rd_v;
  logic [ADDR_W-1:0] sweep_addr;
  ram_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .busy       (busy),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );
  assign rd_req = cs && !we && !busy;
  always_ff @(posedge clk)
    if (sweep_we) mem[sweep_addr] <= CLEAR_VAL;
    else if (cs && we)
      for (int i = 0; i < BE_W; i++)
        if (be[i]) mem[a][8*i +: 8] <= di[8*i +: 8];
  // the extra stage keeps a read issued before clr on its pre-clear data
  if (RD_LAT == 2) begin : g_lat2
    logic              p_v;
    logic [DATA_W-1:0] p_data;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        p_v    <= 1'b0;
        p_data <= '0;
      end else begin
        p_v <= rd_req;
        if (rd_req) p_data <= mem[a];
      end
    assign rd_v    = p_v;
    assign rd_data = p_data;
  end else begin : g_lat1
    assign rd_v    = rd_req;
    assign rd_data = mem[a];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout_reg <= '0;
      rvalid   <= 1'b0;
    end else begin
      rvalid <= rd_v;
      if (rd_v) dout_reg <= rd_data;
    end
  assign dout = oe ? dout_reg : '0;
endmodule

// File: tb/tb_ram_sp_be_init.sv
// tb_ram_sp_be_init: checks the RAM at read latency 1 and 2 against a scoreboard model
module tb_ram_sp_be_init;
  logic        clk = 1'b0, rst = 1'b1, cs = 1'b0, we = 1'b0, oe = 1'b1, clr = 1'b0;
  logic [3:0]  be = '0;
  logic [7:0]  a = '0;
  logic [31:0] di = '0;
  logic [31:0] dout1, dout2;
  logic        rv1, rv2, busy1, busy2;
  int          passed = 0, total = 0;
  logic [31:0] mdl [256];
  typedef struct {
    logic        cs, we;
    logic [3:0]  be;
    logic [7:0]  a;
    logic [31:0] di;
    logic        oe, rv, cd;
    logic [31:0] dout;
  } vec_t;
  vec_t tbl [12];

  ram_sp_be_init #(.DATA_W(32), .ADDR_W(8), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .a(a), .di(di), .oe(oe), .clr(clr),
    .dout(dout1), .rvalid(rv1), .busy(busy1));
  ram_sp_be_init #(.DATA_W(32), .ADDR_W(8), .RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .be(be), .a(a), .di(di), .oe(oe), .clr(clr),
    .dout(dout2), .rvalid(rv2), .busy(busy2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic count_busy(input bit poke);
    int n = 0;
    do begin
      cs = poke;
      we = poke ? n[0] : 1'b0;
      be = 4'hF;
      a  = 8'($urandom);
      di = $urandom | 32'h1;
      step();
      n++;
      if (poke) chk("busy_rvalid", {31'b0, rv1}, 32'd0);
    end while (busy1 && n < 1000);
    cs = 1'b0;
    chk("busy_cycles", n, 32'd256);
    chk("busy2_low", {31'b0, busy2}, 32'd0);
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 256; i++) begin
      cs = 1'b1; we = 1'b0; a = 8'(i);
      step();
      chk("zero_dout", dout1, 32'd0);
      chk("zero_rvalid", {31'b0, rv1}, 32'd1);
    end
    cs = 1'b0;
    step();
    chk("zero_dout2", dout2, 32'd0);
    chk("zero_rv_end", {31'b0, rv1}, 32'd0);
  endtask

  initial begin
    logic [31:0] exp1_d, exp2_d, prev_d, rd_d;
    logic        exp1_v, exp2_v, prev_v, rd;
    tbl[0]  = '{1'b1, 1'b1, 4'hF, 8'd5, 32'hAABBCCDD, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{1'b1, 1'b1, 4'h5, 8'd5, 32'h11223344, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 4'h0, 8'd5, 32'h0,        1'b1, 1'b1, 1'b1, 32'hAA22CC44};
    tbl[3]  = '{1'b1, 1'b1, 4'hF, 8'd7, 32'h0000BEEF, 1'b1, 1'b0, 1'b1, 32'hAA22CC44};
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 8'd7, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000BEEF};
    tbl[5]  = '{1'b1, 1'b1, 4'h0, 8'd7, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h0000BEEF};
    tbl[6]  = '{1'b0, 1'b0, 4'h0, 8'd7, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0000BEEF};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 8'd7, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000BEEF};
    tbl[8]  = '{1'b0, 1'b1, 4'hF, 8'd7, 32'hDEADDEAD, 1'b1, 1'b0, 1'b1, 32'h0000BEEF};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 8'd7, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0000BEEF};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 8'd5, 32'h0,        1'b0, 1'b1, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 1'b0, 4'h0, 8'd5, 32'h0,        1'b1, 1'b0, 1'b1, 32'hAA22CC44};

    // reset state, then the power-up sweep
    step(); step();
    chk("rst_busy", {31'b0, busy1}, 32'd1);
    chk("rst_rvalid", {31'b0, rv1}, 32'd0);
    chk("rst_dout", dout1, 32'd0);
    rst = 1'b0;
    count_busy(1'b0);
    read_all_zero();

    // fill and readback at both latencies
    for (int i = 0; i < 256; i++) begin
      mdl[i] = $urandom;
      cs = 1'b1; we = 1'b1; be = 4'hF; a = 8'(i); di = mdl[i];
      step();
    end
    for (int i = 0; i < 256; i++) begin
      cs = 1'b1; we = 1'b0; a = 8'(i);
      step();
      chk("fill_rd1", dout1, mdl[i]);
      chk("fill_rv1", {31'b0, rv1}, 32'd1);
      chk("fill_rv2", {31'b0, rv2}, i > 0 ? 32'd1 : 32'd0);
      if (i > 0) chk("fill_rd2", dout2, mdl[i-1]);
    end
    cs = 1'b0;
    step();
    chk("fill_rd2_last", dout2, mdl[255]);
    chk("fill_rv1_end", {31'b0, rv1}, 32'd0);

    // random traffic on a few addresses against the scoreboard
    exp1_d = mdl[255]; exp2_d = mdl[255];
    prev_v = 1'b0; prev_d = '0;
    for (int k = 0; k < 300; k++) begin
      cs = ($urandom % 4) != 0;
      we = 1'($urandom);
      be = 4'($urandom);
      a  = 8'($urandom % 16);
      di = $urandom;
      rd = cs && !we;
      rd_d = mdl[a];
      if (cs && we)
        for (int b = 0; b < 4; b++)
          if (be[b]) mdl[a][8*b +: 8] = di[8*b +: 8];
      step();
      if (prev_v) exp2_d = prev_d;
      exp2_v = prev_v;
      if (rd) exp1_d = rd_d;
      exp1_v = rd;
      prev_v = rd; prev_d = rd_d;
      chk("rnd_dout1", dout1, exp1_d);
      chk("rnd_rv1", {31'b0, rv1}, {31'b0, exp1_v});
      chk("rnd_dout2", dout2, exp2_d);
      chk("rnd_rv2", {31'b0, rv2}, {31'b0, exp2_v});
    end

    // byte enables, read-after-write, cs gating, oe gating
    for (int i = 0; i < 12; i++) begin
      cs = tbl[i].cs; we = tbl[i].we; be = tbl[i].be; a = tbl[i].a; di = tbl[i].di; oe = tbl[i].oe;
      step();
      chk($sformatf("vec%0d_rvalid", i), {31'b0, rv1}, {31'b0, tbl[i].rv});
      if (tbl[i].cd) chk($sformatf("vec%0d_dout", i), dout1, tbl[i].dout);
    end

    // read in flight across clr, dropped writes while busy, rst mid-sweep
    cs = 1'b1; we = 1'b0; a = 8'd5; oe = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0;
    chk("clr_rd1", dout1, 32'hAA22CC44);
    chk("clr_rv1", {31'b0, rv1}, 32'd1);
    chk("clr_busy", {31'b0, busy1}, 32'd1);
    we = 1'b1; be = 4'hF; di = 32'hFFFFFFFF;
    step();
    chk("clr_rd2", dout2, 32'hAA22CC44);
    chk("clr_rv2", {31'b0, rv2}, 32'd1);
    chk("clr_rv1_off", {31'b0, rv1}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cs = 1'b1; we = 1'b1; a = 8'(i); di = 32'hFFFFFFFF;
      step();
    end
    rst = 1'b1;
    step();
    chk("rst2_busy", {31'b0, busy1}, 32'd1);
    chk("rst2_dout", dout1, 32'd0);
    rst = 1'b0;
    count_busy(1'b1);
    read_all_zero();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
